exmem_wb_stage: RTL and testbench
=================================

Name: exmem_wb_stage

Overview:
- Pipeline register and writeback stage directly downstream of the EXMEM stage.
- Captures the EXMEM result, destination and control each cycle and selects ALU or dmem load data.
- Drives the register-file write port with per-byte enables derived from ppp.
- Generates the WB→EXMEM forwarding selects and WB_data, and counts retired instructions.

Parameters:
- DATA_W, 64, datapath width; must be a multiple of 8.
- REG_AW, 5, register address width.
- RET_W, 32, retired-instruction counter width.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-low reset
- EXMEM_ALU_out  in  DATA_W  ALU result from EXMEM
- dmem_data_out  in  DATA_W  dmem read data; valid in the cycle EXMEM_stall deasserts on a load
- EXMEM_rD  in  REG_AW  destination register
- EXMEM_ppp  in  3  participating-byte field
- EXMEM_wrEn  in  1  register write enable
- EXMEM_rD_data_select  in  1  1 = mem data, 0 = ALU
- EXMEM_stall  in  1  EXMEM load stall; WB inserts a bubble
- IDEX_rA, IDEX_rB  in  REG_AW each  source registers of the instruction entering EXMEM next cycle
- IDEX_valid  in  1  IDEX holds a real instruction
- WB_data  out  DATA_W  registered writeback data; also the forwarding value
- WB_rD  out  REG_AW  registered destination
- WB_byte_en  out  8  register-file byte write enables; bit 0 = bytes [0:7] (MSB)
- WB_wrEn  out  1  register-file write strobe
- EXMEM_forward_rA, EXMEM_forward_rB  out  1 each  registered forwarding selects to EXMEM
- WB_hazard  out  1  partial-write RAW hazard; upstream holds IF/ID/IDEX for one cycle
- ret_count  out  RET_W  retired instructions

Behaviour:
- Reset (reset=0, asynchronous): all outputs 0, all internal state 0. Release is sampled on the next clk edge.
- Capture on every posedge. Latency is 1 cycle from EXMEM inputs to WB_* outputs.
- Bubble: if EXMEM_stall=1, capture WB_wrEn=0 and WB_byte_en=0.
  - WB_data and WB_rD still update (don't-care).
  - Bubbles do not count as retired.
- Data select: WB_data <= EXMEM_rD_data_select ? dmem_data_out : EXMEM_ALU_out.
- ppp decode to byte_en, MSB-first:
  - 000 → FF (all bytes)
  - 001 → F0 (bytes 0-3)
  - 010 → 0F (bytes 4-7)
  - 011 → AA (even bytes 0,2,4,6)
  - 100 → 55 (odd bytes)
  - 101/110/111 → 00, and the instruction is still counted retired.
- R0 suppression: if EXMEM_rD==0, WB_wrEn=0 and WB_byte_en=0 (R0 is hardwired zero). The instruction is still retired.
- WB_wrEn = EXMEM_wrEn && !stall && rD!=0 && byte_en!=0.
- Forwarding, registered, evaluated against the values being captured this edge:
  - fwd_rA <= IDEX_valid && next_wrEn && next_byte_en==FF && IDEX_rA==EXMEM_rD.
  - fwd_rB is the same with IDEX_rB.
- Partial hazard (WB_hazard, combinational from registered state): IDEX_valid && WB_wrEn && WB_byte_en!=FF && (IDEX_rA==WB_rD || IDEX_rB==WB_rD).
  - Forwarding is never asserted for partial writes.
  - Upstream must hold one cycle so the regfile write lands.
- Forward-select lifetime: a forward select is held only while WB_* reflects the matched instruction. If EXMEM_stall=1 on the next edge, the selects clear with the bubble; the data is by then in the regfile.
- ret_count: increments by 1 on each edge that captures a non-bubble instruction (EXMEM_stall=0 and EXMEM_wrEn or EXMEM_rD_data_select or IDEX_valid-tracked issue).
  - Simplified rule: count when EXMEM_stall=0 and (EXMEM_wrEn=1 or EXMEM_rD_data_select=1).
  - Wraps modulo 2^RET_W without saturation.
- Simultaneous events:
  - stall and forward match in the same cycle → stall wins; no forward, no write.
  - reset asserted mid-load → all cleared immediately; no partial writeback.

Test Plan:
- Reset then ALU op: wrEn=1, rD=3, ppp=000, ALU_out=0x0123456789ABCDEF. Next cycle: WB_data=0x0123456789ABCDEF, WB_byte_en=FF, WB_wrEn=1, ret_count=1.
- Load with 2-cycle stall: EXMEM_stall=1,1,0 with select=1, dmem=0xDEADBEEF00000000 on the third cycle. WB_wrEn=0 for two cycles, then 1 with that data; ret_count increments once.
- ppp sweep 000..111 with rD=5. WB_byte_en: FF, F0, 0F, AA, 55, 00, 00, 00; WB_wrEn=0 for the last three.
- Forwarding: EXMEM rD=7 ppp=000 while IDEX_rA=7, IDEX_rB=2, valid=1 → fwd_rA=1, fwd_rB=0. Repeat with ppp=001 → fwd_rA=0, WB_hazard=1 for one cycle.
- rD=0 with wrEn=1: WB_wrEn=0, no forwarding even if IDEX_rA=0; ret_count still increments.
- Assert reset mid-stream with WB_wrEn=1 and fwd_rB=1: all outputs 0 immediately, before the next clk edge. Also set ret_count near 2^32-1 via a long run or force, and check it wraps to 0.

Source files
------------

// File: rtl/exmem_wb_stage.sv
// Writeback pipeline register downstream of EXMEM: selects ALU or load data,
// drives the register-file write port and forwarding selects, counts retirements.
module exmem_wb_stage #(
    parameter int DATA_W = 64,
    parameter int REG_AW = 5,
    parameter int RET_W  = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] EXMEM_ALU_out,
    input  logic [DATA_W-1:0] dmem_data_out,
    input  logic [REG_AW-1:0] EXMEM_rD,
    input  logic [2:0]        EXMEM_ppp,
    input  logic              EXMEM_wrEn,
    input  logic              EXMEM_rD_data_select,
    input  logic              EXMEM_stall,
    input  logic [REG_AW-1:0] IDEX_rA,
    input  logic [REG_AW-1:0] IDEX_rB,
    input  logic              IDEX_valid,
    output logic [DATA_W-1:0] WB_data,
    output logic [REG_AW-1:0] WB_rD,
    output logic [7:0]        WB_byte_en,
    output logic              WB_wrEn,
    output logic              EXMEM_forward_rA,
    output logic              EXMEM_forward_rB,
    output logic              WB_hazard,
    output logic [RET_W-1:0]  ret_count
);

    logic [DATA_W-1:0] r_data;
    logic [REG_AW-1:0] r_rD;
    logic [7:0]        r_byteEn;
    logic              r_wrEn;
    logic              r_fwdA;
    logic              r_fwdB;
    logic [RET_W-1:0]  r_retCount;

    logic [7:0]        w_byteEnDec;
    logic [7:0]        w_nextByteEn;
    logic              w_nextWrEn;
    logic              w_fwdA;
    logic              w_fwdB;
    logic              w_retire;
    logic [DATA_W-1:0] w_nextData;

    // Byte enables are MSB-first: the upper nibble covers bytes 0-3.
    always_comb begin
        w_byteEnDec = 8'h00;
        case (EXMEM_ppp)
            3'b000:  w_byteEnDec = 8'hFF;
            3'b001:  w_byteEnDec = 8'hF0;
            3'b010:  w_byteEnDec = 8'h0F;
            3'b011:  w_byteEnDec = 8'hAA;
            3'b100:  w_byteEnDec = 8'h55;
            default: w_byteEnDec = 8'h00;
        endcase
    end

    // A bubble or an R0 destination must never reach the register file.
    always_comb begin
        w_nextByteEn = w_byteEnDec;
        if (EXMEM_stall || (EXMEM_rD == '0)) begin
            w_nextByteEn = 8'h00;
        end
        w_nextWrEn = EXMEM_wrEn && !EXMEM_stall && (EXMEM_rD != '0) && (w_nextByteEn != 8'h00);
        w_fwdA     = IDEX_valid && w_nextWrEn && (w_nextByteEn == 8'hFF) && (IDEX_rA == EXMEM_rD);
        w_fwdB     = IDEX_valid && w_nextWrEn && (w_nextByteEn == 8'hFF) && (IDEX_rB == EXMEM_rD);
        w_retire   = !EXMEM_stall && (EXMEM_wrEn || EXMEM_rD_data_select);
        w_nextData = EXMEM_rD_data_select ? dmem_data_out : EXMEM_ALU_out;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_data     <= '0;
            r_rD       <= '0;
            r_byteEn   <= '0;
            r_wrEn     <= 1'b0;
            r_fwdA     <= 1'b0;
            r_fwdB     <= 1'b0;
            r_retCount <= '0;
        end else begin
            r_data   <= w_nextData;
            r_rD     <= EXMEM_rD;
            r_byteEn <= w_nextByteEn;
            r_wrEn   <= w_nextWrEn;
            r_fwdA   <= w_fwdA;
            r_fwdB   <= w_fwdB;
            if (w_retire) begin
                r_retCount <= r_retCount + 1'b1;
            end
        end
    end

    assign WB_data          = r_data;
    assign WB_rD            = r_rD;
    assign WB_byte_en       = r_byteEn;
    assign WB_wrEn          = r_wrEn;
    assign EXMEM_forward_rA = r_fwdA;
    assign EXMEM_forward_rB = r_fwdB;
    assign ret_count        = r_retCount;

    // A partial write in flight cannot be forwarded, so a dependent reader must wait.
    assign WB_hazard = IDEX_valid && r_wrEn && (r_byteEn != 8'hFF)
                       && ((IDEX_rA == r_rD) || (IDEX_rB == r_rD));

endmodule

// File: tb/tb_exmem_wb_stage.sv
// Directed bench for exmem_wb_stage: a vector table walked cycle by cycle,
// then hand-written reset sequences; a narrow-counter copy exercises wrap-around.
module tb_exmem_wb_stage;

    logic        clk;
    logic        reset;
    logic [63:0] aluOut;
    logic [63:0] dmemOut;
    logic [4:0]  exRd;
    logic [2:0]  exPpp;
    logic        exWrEn;
    logic        exSel;
    logic        exStall;
    logic [4:0]  idRa;
    logic [4:0]  idRb;
    logic        idValid;

    logic [63:0] wbData;
    logic [4:0]  wbRd;
    logic [7:0]  wbByteEn;
    logic        wbWrEn;
    logic        fwdA;
    logic        fwdB;
    logic        wbHazard;
    logic [31:0] retCount;

    logic [63:0] wrapData;
    logic [4:0]  wrapRd;
    logic [7:0]  wrapByteEn;
    logic        wrapWrEn;
    logic        wrapFwdA;
    logic        wrapFwdB;
    logic        wrapHazard;
    logic [2:0]  wrapRet;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic        stall;
        logic        wrEn;
        logic        sel;
        logic [4:0]  rD;
        logic [2:0]  ppp;
        logic [63:0] alu;
        logic [63:0] dmem;
        logic [4:0]  rA;
        logic [4:0]  rB;
        logic        valid;
        logic [63:0] expData;
        logic [4:0]  expRd;
        logic [7:0]  expBe;
        logic        expWr;
        logic        expFa;
        logic        expFb;
        logic        expHz;
        logic [31:0] expRet;
    } vec_t;

    vec_t vecs [18];

    exmem_wb_stage #(.DATA_W(64), .REG_AW(5), .RET_W(32)) dut (
        .clk                  (clk),
        .reset                (reset),
        .EXMEM_ALU_out        (aluOut),
        .dmem_data_out        (dmemOut),
        .EXMEM_rD             (exRd),
        .EXMEM_ppp            (exPpp),
        .EXMEM_wrEn           (exWrEn),
        .EXMEM_rD_data_select (exSel),
        .EXMEM_stall          (exStall),
        .IDEX_rA              (idRa),
        .IDEX_rB              (idRb),
        .IDEX_valid           (idValid),
        .WB_data              (wbData),
        .WB_rD                (wbRd),
        .WB_byte_en           (wbByteEn),
        .WB_wrEn              (wbWrEn),
        .EXMEM_forward_rA     (fwdA),
        .EXMEM_forward_rB     (fwdB),
        .WB_hazard            (wbHazard),
        .ret_count            (retCount)
    );

    // Same stimulus into a 3-bit counter copy so wrap-around shows up after eight retirements.
    exmem_wb_stage #(.DATA_W(64), .REG_AW(5), .RET_W(3)) wrapDut (
        .clk                  (clk),
        .reset                (reset),
        .EXMEM_ALU_out        (aluOut),
        .dmem_data_out        (dmemOut),
        .EXMEM_rD             (exRd),
        .EXMEM_ppp            (exPpp),
        .EXMEM_wrEn           (exWrEn),
        .EXMEM_rD_data_select (exSel),
        .EXMEM_stall          (exStall),
        .IDEX_rA              (idRa),
        .IDEX_rB              (idRb),
        .IDEX_valid           (idValid),
        .WB_data              (wrapData),
        .WB_rD                (wrapRd),
        .WB_byte_en           (wrapByteEn),
        .WB_wrEn              (wrapWrEn),
        .EXMEM_forward_rA     (wrapFwdA),
        .EXMEM_forward_rB     (wrapFwdB),
        .WB_hazard            (wrapHazard),
        .ret_count            (wrapRet)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive one EXMEM/IDEX record, let it be captured, and settle just past the edge.
    task automatic applyStimulus(input vec_t v);
        exStall = v.stall;
        exWrEn  = v.wrEn;
        exSel   = v.sel;
        exRd    = v.rD;
        exPpp   = v.ppp;
        aluOut  = v.alu;
        dmemOut = v.dmem;
        idRa    = v.rA;
        idRb    = v.rB;
        idValid = v.valid;
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
        end
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, " WB_data"}, wbData, 64'h0);
        checkOutput({tag, " WB_rD"}, {59'h0, wbRd}, 64'h0);
        checkOutput({tag, " WB_byte_en"}, {56'h0, wbByteEn}, 64'h0);
        checkOutput({tag, " WB_wrEn"}, {63'h0, wbWrEn}, 64'h0);
        checkOutput({tag, " fwd_rA"}, {63'h0, fwdA}, 64'h0);
        checkOutput({tag, " fwd_rB"}, {63'h0, fwdB}, 64'h0);
        checkOutput({tag, " WB_hazard"}, {63'h0, wbHazard}, 64'h0);
        checkOutput({tag, " ret_count"}, {32'h0, retCount}, 64'h0);
    endtask

    initial begin
        //                 stall wr sel rD   ppp   alu                    dmem                   rA    rB    vld expData                expRd expBe  wr fA fB hz ret
        vecs[0]  = '{1'b0, 1'b1, 1'b0, 5'd3, 3'd0, 64'h0123456789ABCDEF, 64'h0,                 5'd0, 5'd0, 1'b0, 64'h0123456789ABCDEF, 5'd3, 8'hFF, 1'b1, 1'b0, 1'b0, 1'b0, 32'd1};
        vecs[1]  = '{1'b1, 1'b1, 1'b1, 5'd9, 3'd0, 64'h1111,             64'h0,                 5'd0, 5'd0, 1'b0, 64'h0,                 5'd9, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 32'd1};
        vecs[2]  = '{1'b1, 1'b1, 1'b1, 5'd9, 3'd0, 64'h1111,             64'h0,                 5'd0, 5'd0, 1'b0, 64'h0,                 5'd9, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 32'd1};
        vecs[3]  = '{1'b0, 1'b1, 1'b1, 5'd9, 3'd0, 64'h1111,             64'hDEADBEEF00000000, 5'd0, 5'd0, 1'b0, 64'hDEADBEEF00000000, 5'd9, 8'hFF, 1'b1, 1'b0, 1'b0, 1'b0, 32'd2};
        vecs[4]  = '{1'b0, 1'b1, 1'b0, 5'd5, 3'd0, 64'h50,               64'h0,                 5'd0, 5'd0, 1'b0, 64'h50,                5'd5, 8'hFF, 1'b1, 1'b0, 1'b0, 1'b0, 32'd3};
        vecs[5]  = '{1'b0, 1'b1, 1'b0, 5'd5, 3'd1, 64'h51,               64'h0,                 5'd0, 5'd0, 1'b0, 64'h51,                5'd5, 8'hF0, 1'b1, 1'b0, 1'b0, 1'b0, 32'd4};
        vecs[6]  = '{1'b0, 1'b1, 1'b0, 5'd5, 3'd2, 64'h52,               64'h0,                 5'd0, 5'd0, 1'b0, 64'h52,                5'd5, 8'h0F, 1'b1, 1'b0, 1'b0, 1'b0, 32'd5};
        vecs[7]  = '{1'b0, 1'b1, 1'b0, 5'd5, 3'd3, 64'h53,               64'h0,                 5'd0, 5'd0, 1'b0, 64'h53,                5'd5, 8'hAA, 1'b1, 1'b0, 1'b0, 1'b0, 32'd6};
        vecs[8]  = '{1'b0, 1'b1, 1'b0, 5'd5, 3'd4, 64'h54,               64'h0,                 5'd0, 5'd0, 1'b0, 64'h54,                5'd5, 8'h55, 1'b1, 1'b0, 1'b0, 1'b0, 32'd7};
        vecs[9]  = '{1'b0, 1'b1, 1'b0, 5'd5, 3'd5, 64'h55,               64'h0,                 5'd0, 5'd0, 1'b0, 64'h55,                5'd5, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 32'd8};
        vecs[10] = '{1'b0, 1'b1, 1'b0, 5'd5, 3'd6, 64'h56,               64'h0,                 5'd0, 5'd0, 1'b0, 64'h56,                5'd5, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 32'd9};
        vecs[11] = '{1'b0, 1'b1, 1'b0, 5'd5, 3'd7, 64'h57,               64'h0,                 5'd0, 5'd0, 1'b0, 64'h57,                5'd5, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 32'd10};
        vecs[12] = '{1'b0, 1'b1, 1'b0, 5'd7, 3'd0, 64'h77,               64'h0,                 5'd7, 5'd2, 1'b1, 64'h77,                5'd7, 8'hFF, 1'b1, 1'b1, 1'b0, 1'b0, 32'd11};
        vecs[13] = '{1'b0, 1'b1, 1'b0, 5'd7, 3'd1, 64'h78,               64'h0,                 5'd7, 5'd2, 1'b1, 64'h78,                5'd7, 8'hF0, 1'b1, 1'b0, 1'b0, 1'b1, 32'd12};
        vecs[14] = '{1'b0, 1'b0, 1'b0, 5'd0, 3'd0, 64'h0,                64'h0,                 5'd7, 5'd2, 1'b1, 64'h0,                 5'd0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 32'd12};
        vecs[15] = '{1'b0, 1'b1, 1'b0, 5'd0, 3'd0, 64'h99,               64'h0,                 5'd0, 5'd0, 1'b1, 64'h99,                5'd0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 32'd13};
        vecs[16] = '{1'b1, 1'b1, 1'b0, 5'd6, 3'd0, 64'h66,               64'h0,                 5'd6, 5'd6, 1'b1, 64'h66,                5'd6, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 32'd13};
        vecs[17] = '{1'b0, 1'b1, 1'b0, 5'd4, 3'd0, 64'h44,               64'h0,                 5'd1, 5'd4, 1'b1, 64'h44,                5'd4, 8'hFF, 1'b1, 1'b0, 1'b1, 1'b0, 32'd14};

        reset   = 1'b0;
        exStall = 1'b0;
        exWrEn  = 1'b0;
        exSel   = 1'b0;
        exRd    = '0;
        exPpp   = '0;
        aluOut  = '0;
        dmemOut = '0;
        idRa    = '0;
        idRb    = '0;
        idValid = 1'b0;
        #3;
        checkAllZero("reset");
        @(posedge clk);
        #1;
        reset = 1'b1;

        for (int i = 0; i < 18; i++) begin
            applyStimulus(vecs[i]);
            checkOutput($sformatf("v%0d WB_data", i), wbData, vecs[i].expData);
            checkOutput($sformatf("v%0d WB_rD", i), {59'h0, wbRd}, {59'h0, vecs[i].expRd});
            checkOutput($sformatf("v%0d WB_byte_en", i), {56'h0, wbByteEn}, {56'h0, vecs[i].expBe});
            checkOutput($sformatf("v%0d WB_wrEn", i), {63'h0, wbWrEn}, {63'h0, vecs[i].expWr});
            checkOutput($sformatf("v%0d fwd_rA", i), {63'h0, fwdA}, {63'h0, vecs[i].expFa});
            checkOutput($sformatf("v%0d fwd_rB", i), {63'h0, fwdB}, {63'h0, vecs[i].expFb});
            checkOutput($sformatf("v%0d WB_hazard", i), {63'h0, wbHazard}, {63'h0, vecs[i].expHz});
            checkOutput($sformatf("v%0d ret_count", i), {32'h0, retCount}, {32'h0, vecs[i].expRet});
            checkOutput($sformatf("v%0d ret_wrap", i), {61'h0, wrapRet}, {61'h0, vecs[i].expRet[2:0]});
        end

        // Vector 17 left WB_wrEn=1 and fwd_rB=1; reset must clear everything without a clock edge.
        #1;
        reset = 1'b0;
        #1;
        checkAllZero("async reset");
        checkOutput("async reset ret_wrap", {61'h0, wrapRet}, 64'h0);

        // Reset held across an edge while a load completes: nothing may be written back.
        exStall = 1'b0;
        exSel   = 1'b1;
        exWrEn  = 1'b1;
        exRd    = 5'd8;
        dmemOut = 64'hCAFEF00D12345678;
        @(posedge clk);
        #1;
        checkAllZero("held reset");

        // First instruction after release counts from zero again.
        reset = 1'b1;
        applyStimulus('{1'b0, 1'b1, 1'b0, 5'd2, 3'd0, 64'hABCD, 64'h0, 5'd0, 5'd0, 1'b0,
                        64'h0, 5'd0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0});
        checkOutput("post-reset WB_data", wbData, 64'hABCD);
        checkOutput("post-reset WB_wrEn", {63'h0, wbWrEn}, 64'h1);
        checkOutput("post-reset ret_count", {32'h0, retCount}, 64'h1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
